// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch port and the
//   load/store port. A four-state FSM (IDLE, FETCH, DATA, RESP) grants one
//   request at a time. The data port has fixed priority over fetch. Each
//   transaction ends with a one-cycle valid pulse to its owner.
//
// Ports
//   clk, reset              clock; asynchronous active-low reset
//   if_req/if_addr          fetch request (level) and byte address
//   if_rdata/if_valid       fetched word and one-cycle completion pulse
//   mem_req/mem_we          load/store request (level); 1 = store
//   mem_addr/mem_wdata      data address and store data
//   mem_rdata/mem_valid     load data (0 after a store) and completion pulse
//   StallF/StallM           stall requests to the hazard unit
//   m_req/m_we/m_addr/m_wdata  memory command, held for the whole access
//   m_rdata/m_ready         memory read data and completion
//   bus_err                 (MEM_ARB_TIMEOUT_EN only) pulses together with
//                           valid when an access times out
//
// Build option
//   MEM_ARB_TIMEOUT_EN  adds a 4-bit wait counter. After 15 cycles of
//                       m_ready=0, the access completes with data 0 and
//                       bus_err is raised.
module mem_port_arbiter (
`ifdef MEM_ARB_TIMEOUT_EN
  output logic        bus_err,
`endif
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        StallF,
  output logic        StallM,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner_m;   // 1: current transaction belongs to the data port
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_grant_m;
  logic        w_grant_f;
  logic        w_done;
  logic        w_busy;
  logic        w_timeout;

  assign w_busy = (r_state == FETCH) || (r_state == DATA);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and grant decode
  always_comb begin
    w_state_nxt = r_state;
    w_grant_m   = 1'b0;
    w_grant_f   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_req) begin
          w_grant_m   = 1'b1;
          w_state_nxt = DATA;
        end else if (if_req) begin
          w_grant_f   = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH, DATA: begin
        if (m_ready || w_timeout) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command registers are loaded only on grant. This keeps m_* stable for
  // the whole access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner_m <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_grant_m || w_grant_f) begin
        r_owner_m <= w_grant_m;
        r_we      <= w_grant_m & mem_we;
        r_addr    <= w_grant_m ? mem_addr  : if_addr;
        r_wdata   <= w_grant_m ? mem_wdata : '0;
      end
      // A store or a timed-out access returns 0 rather than bus data.
      if (w_done) r_rdata <= (m_ready && !r_we) ? m_rdata : '0;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [3:0] r_wait_cnt;
  logic       r_bus_err;

  // The 15th consecutive wait cycle ends the access.
  assign w_timeout = w_busy && !m_ready && (r_wait_cnt == 4'd14);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_grant_m || w_grant_f)  r_wait_cnt <= '0;
      else if (w_busy && !m_ready) r_wait_cnt <= r_wait_cnt + 4'd1;
      // Set on the edge that enters RESP. Cleared on the edge that leaves it.
      r_bus_err <= w_timeout;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
`endif

  assign m_req     = w_busy;
  assign m_we      = r_we;
  assign m_addr    = r_addr;
  assign m_wdata   = r_wdata;

  assign if_valid  = (r_state == RESP) && !r_owner_m;
  assign mem_valid = (r_state == RESP) &&  r_owner_m;
  assign if_rdata  = if_valid  ? r_rdata : '0;
  assign mem_rdata = mem_valid ? r_rdata : '0;

  assign StallF    = if_req  & ~if_valid;
  assign StallM    = mem_req & ~mem_valid;

endmodule
